ijtag_multi_local_reset_tdr: RTL and testbench
==============================================

// Module: ijtag_multi_local_reset_tdr
// PURPOSE
//  Next-generation local-reset TDR on the IJTAG network: one scan segment drives NUM_CH
//  independent local reset outputs, each passing ijtag_reset through or overriding it.
//  Each channel has a level mode (reset held at a programmed value) and a self-clearing
//  pulse mode: a programmable-width active-low pulse, after which the override drops by itself.
//  Sits between a parent SIB/TDR and child SIB/TDR ijtag_reset inputs, as the per-block reset TDR.
// PARAMETERS
//  NUM_CH    4   number of local reset channels (>=1)
//  PW_W      4   width of pulse-width field and per-channel down-counters (>=1)
//  PW_RESET  3   reset value of pulse-width field (pulse = PW+1 tck periods)
// PORTS
//  ijtag_tck       in   1            single clock; shift/capture on rise, update/counters/so on fall
//  ijtag_reset     in   1            asynchronous, active-low reset; also pass-through source
//  ijtag_sel       in   1            segment select
//  ijtag_si        in   1            scan in (enters at MSB of shift register)
//  ijtag_ce        in   1            capture enable
//  ijtag_se        in   1            shift enable
//  ijtag_ue        in   1            update enable
//  ijtag_so        out  1            scan out, retimed to falling edge
//  ijtag_to_reset  out  NUM_CH       active-low local resets to child logic
// BEHAVIOUR
//  Register length L = 3*NUM_CH+PW_W. Fields (shift and update): [N-1:0] ovr, [2N-1:N] val,
//   [3N-1:2N] mode, [L-1:3N] pw. The ovr field is bits [N-1:0], so ijtag_so shifts out ovr[0] first.
//  Shift reg, rising tck: ce&sel -> capture update image (live ovr); else se&sel -> {si,sr[L-1:1]}.
//   ce has priority over se. No capture/shift when sel=0.
//  so flop: falling tck, so <= sr[0].
//  Async reset (ijtag_reset=0): shift reg and update reg -> ovr=0, val=1, mode=0, pw=PW_RESET;
//   counters=0; so=0. ijtag_to_reset = all bits follow ijtag_reset (=0) immediately.
//  Update, falling tck with ue&sel: the update reg loads the shift reg.
//  Output per channel i:
//   ovr=0                 -> to_reset[i] = ijtag_reset (combinational pass-through)
//   ovr=1, mode=0         -> to_reset[i] = val[i] (level override; can hold child in or out of reset)
//   ovr=1, mode=1         -> to_reset[i] = 0 (pulse active); val[i] ignored
//  Pulse mode, per channel (one FSM: IDLE/PULSE, PULSE == ovr&mode):
//   - An update writing ovr=1,mode=1 loads cnt[i] <= pw. PULSE is entered on that falling edge.
//   - At each later falling edge without a retriggering update: if cnt!=0, cnt--; if cnt==0,
//     ovr[i] <= 0 (self-clear) and the channel returns to pass-through.
//   - Low time = pw+1 tck periods. pw=0 gives 1 period; pw=2^PW_W-1 is the max and does not wrap.
//   - An update during PULSE with ovr=1,mode=1 reloads cnt with the new pw (retrigger, extends pulse).
//   - An update during PULSE with ovr=0 aborts the pulse immediately. mode=0,ovr=1 switches to level val.
//   - A self-clear edge that coincides with an update: the update wins.
//   - An update with sel=0 is ignored, and a running pulse continues counting.
//   - Capture of ovr during/after a pulse returns 1 during the pulse and 0 after self-clear.
//  Asserting ijtag_reset mid-pulse aborts the pulse (ovr=0, cnt=0); output follows reset.
//  Channels are fully independent; a pulse counter is shared by no other channel.
//  No combinational path from si/sel/ue to ijtag_to_reset; ijtag_reset->to_reset only when ovr=0.
// TESTING (NUM_CH=4, PW_W=4, PW_RESET=3)
//  Reset then capture+shift 16 -> so stream is ovr=0000,val=1111,mode=0000,pw=0011. to_reset follows ijtag_reset.
//  Level: update ovr=0101,val=0000,mode=0 -> to_reset=1010 while ijtag_reset=1; ovr=0 again -> 1111.
//  Pulse: update ovr=0001,mode=0001,pw=2 -> to_reset[0] low exactly 3 tck periods, then 1; others stay 1.
//   Capture afterwards: ovr[0]=0.
//  Retrigger: pw=5 pulse, update again pw=5 at period 3 -> total low 3+6=9 periods. Abort by ovr=0 -> high next fall.
//  Edge: pw=0 -> 1-period pulse; pw=15 -> 16 periods, no wrap. Update with sel=0 -> no change.
//  Reset mid-pulse: drop ijtag_reset at period 2 -> all outputs 0 asynchronously.
//   After release: pass-through, ovr=0.

Source files
------------

// File: rtl/ijtag_multi_local_reset_tdr.sv
// ---------------------------------------------------------------------------
// ijtag_multi_local_reset_tdr
//   Per-block local-reset TDR on the IJTAG network. A single scan segment
//   drives NUM_CH independent active-low local resets. Each channel either
//   passes ijtag_reset through, holds a programmed level, or emits a
//   self-clearing low pulse of (pw+1) tck periods.
//
//   Scan image (LSB first out of ijtag_so):
//     [N-1:0]  ovr    1 = channel overrides ijtag_reset
//     [2N-1:N] val    level driven when ovr=1, mode=0
//     [3N-1:2N] mode  1 = pulse mode (self-clearing)
//     [L-1:3N] pw     pulse width minus one, shared by all channels
//
// Ports
//   ijtag_tck       clock; shift/capture on rise, update/counters/so on fall
//   ijtag_reset     async active-low reset, also the pass-through source
//   ijtag_sel       segment select
//   ijtag_si        scan in (enters at MSB)
//   ijtag_ce/se/ue  capture / shift / update enables
//   ijtag_so        scan out, retimed to falling edge
//   ijtag_to_reset  [NUM_CH] active-low local resets to child logic
// ---------------------------------------------------------------------------

// One reset channel: update-register bits for ovr/val/mode, the pulse
// down-counter and the IDLE/PULSE FSM. Everything here runs on the
// falling edge so it lines up with the TDR update stage.
module ijtag_lrst_ch #(
    parameter int PW_W = 4
) (
    input  logic            tck,
    input  logic            rst_n,
    input  logic            upd,
    input  logic            upd_ovr,
    input  logic            upd_val,
    input  logic            upd_mode,
    input  logic [PW_W-1:0] upd_pw,
    output logic            ovr,
    output logic            val,
    output logic            mode,
    output logic            to_reset
);
    typedef enum logic {IDLE, PULSE} state_t;

    // PULSE is held exactly when ovr & mode are both set.
    state_t          state_q, state_d;
    logic            ovr_d, val_d, mode_d;
    logic [PW_W-1:0] cnt_q, cnt_d;

    always_ff @(negedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ovr     <= 1'b0;
            val     <= 1'b1;
            mode    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ovr     <= ovr_d;
            val     <= val_d;
            mode    <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ovr_d   = ovr;
        val_d   = val;
        mode_d  = mode;
        cnt_d   = cnt_q;
        if (upd) begin
            // An update always wins, including over a coincident self-clear;
            // rewriting a pulse while one is running restarts its count.
            ovr_d  = upd_ovr;
            val_d  = upd_val;
            mode_d = upd_mode;
            if (upd_ovr && upd_mode) begin
                state_d = PULSE;
                cnt_d   = upd_pw;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (state_q == PULSE) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - PW_W'(1);
            end else begin
                // Self-clear: only ovr drops, mode stays as programmed.
                ovr_d   = 1'b0;
                state_d = IDLE;
            end
        end
    end

    // Only ijtag_reset has a combinational path to the output, and only
    // while the channel is not overriding.
    assign to_reset = !ovr ? rst_n : (mode ? 1'b0 : val);

endmodule

module ijtag_multi_local_reset_tdr #(
    parameter int NUM_CH   = 4,
    parameter int PW_W     = 4,
    parameter int PW_RESET = 3
) (
    input  logic              ijtag_tck,
    input  logic              ijtag_reset,
    input  logic              ijtag_sel,
    input  logic              ijtag_si,
    input  logic              ijtag_ce,
    input  logic              ijtag_se,
    input  logic              ijtag_ue,
    output logic              ijtag_so,
    output logic [NUM_CH-1:0] ijtag_to_reset
);
    localparam int L = 3*NUM_CH + PW_W;

    typedef struct packed {
        logic [PW_W-1:0]   pw;
        logic [NUM_CH-1:0] mode;
        logic [NUM_CH-1:0] val;
        logic [NUM_CH-1:0] ovr;
    } tdr_t;

    localparam logic [L-1:0] RST_IMG =
        {PW_W'(PW_RESET), {NUM_CH{1'b0}}, {NUM_CH{1'b1}}, {NUM_CH{1'b0}}};

    tdr_t              sr;
    tdr_t              img;
    logic [PW_W-1:0]   pw_q;
    logic [NUM_CH-1:0] ovr_q, val_q, mode_q;
    logic              upd;

    assign upd = ijtag_ue & ijtag_sel;

    // Capture returns live ovr, so a finished pulse reads back as 0.
    assign img.pw   = pw_q;
    assign img.mode = mode_q;
    assign img.val  = val_q;
    assign img.ovr  = ovr_q;

    // Shift register: capture has priority over shift.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr <= RST_IMG;
        end else if (ijtag_sel && ijtag_ce) begin
            sr <= img;
        end else if (ijtag_sel && ijtag_se) begin
            sr <= {ijtag_si, sr[L-1:1]};
        end
    end

    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            ijtag_so <= 1'b0;
        end else begin
            ijtag_so <= sr[0];
        end
    end

    // Shared pulse-width field of the update register.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            pw_q <= PW_W'(PW_RESET);
        end else if (upd) begin
            pw_q <= sr.pw;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ijtag_lrst_ch #(.PW_W(PW_W)) u_ch (
            .tck      (ijtag_tck),
            .rst_n    (ijtag_reset),
            .upd      (upd),
            .upd_ovr  (sr.ovr[i]),
            .upd_val  (sr.val[i]),
            .upd_mode (sr.mode[i]),
            .upd_pw   (sr.pw),
            .ovr      (ovr_q[i]),
            .val      (val_q[i]),
            .mode     (mode_q[i]),
            .to_reset (ijtag_to_reset[i])
        );
    end

endmodule

// File: tb/tb_ijtag_multi_local_reset_tdr.sv
// ---------------------------------------------------------------------------
// tb_ijtag_multi_local_reset_tdr
//   Directed stimulus drives scan/update sequences and pushes the expected
//   to_reset / so values, tagged with the rising-edge index at which they
//   must hold, into a scoreboard queue. A monitor pops and compares on each
//   rising tck; a second monitor checks the asynchronous reset response.
// ---------------------------------------------------------------------------
module tb_ijtag_multi_local_reset_tdr;
    localparam int NUM_CH = 4;
    localparam int PW_W   = 4;

    typedef struct {
        int          cyc;
        int          kind;   // 0 to_reset at rise, 1 so at rise, 2 to_reset on reset drop
        logic [15:0] exp;
        string       name;
    } exp_t;

    logic              ijtag_tck   = 1'b0;
    logic              ijtag_reset = 1'b0;
    logic              ijtag_sel   = 1'b0;
    logic              ijtag_si    = 1'b0;
    logic              ijtag_ce    = 1'b0;
    logic              ijtag_se    = 1'b0;
    logic              ijtag_ue    = 1'b0;
    logic              ijtag_so;
    logic [NUM_CH-1:0] ijtag_to_reset;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 ijtag_tck = ~ijtag_tck;

    ijtag_multi_local_reset_tdr #(.NUM_CH(NUM_CH), .PW_W(PW_W), .PW_RESET(3)) dut (
        .ijtag_tck      (ijtag_tck),
        .ijtag_reset    (ijtag_reset),
        .ijtag_sel      (ijtag_sel),
        .ijtag_si       (ijtag_si),
        .ijtag_ce       (ijtag_ce),
        .ijtag_se       (ijtag_se),
        .ijtag_ue       (ijtag_ue),
        .ijtag_so       (ijtag_so),
        .ijtag_to_reset (ijtag_to_reset)
    );

    task automatic compare(input exp_t e, input int kind_seen);
        logic [15:0] got;
        logic [15:0] want;
        checks++;
        if (e.kind == 1) begin
            got  = {15'd0, ijtag_so};
            want = {15'd0, e.exp[0]};
        end else begin
            got  = {12'd0, ijtag_to_reset};
            want = {12'd0, e.exp[3:0]};
        end
        if (e.kind != kind_seen && !(kind_seen == 0 && e.kind == 1)) begin
            errors++;
            $display("FAIL %s cyc=%0d async check not reached before rise", e.name, e.cyc);
        end else if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", e.name, e.cyc, got[3:0], want[3:0]);
        end
    endtask

    // Rising-edge monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge ijtag_tck);
            cyc++;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s missed at cyc=%0d (now %0d)", e.name, e.cyc, cyc);
                end else begin
                    compare(e, 0);
                end
            end
        end
    end

    // Asynchronous reset monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge ijtag_reset);
            #1;
            if (sb.size() > 0 && sb[0].kind == 2) begin
                e = sb.pop_front();
                compare(e, 2);
            end
        end
    end

    task automatic push(input int at, input int kind, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc  = at;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge ijtag_tck);
        #1;
    endtask

    task automatic shift_word(input logic [15:0] w);
        ijtag_se = 1'b1;
        for (int j = 0; j < 16; j++) begin
            ijtag_si = w[j];
            step();
        end
        ijtag_se = 1'b0;
        ijtag_si = 1'b0;
    endtask

    task automatic update();
        ijtag_ue = 1'b1;
        step();
        ijtag_ue = 1'b0;
    endtask

    // Capture, then shift the image out; so bit j is seen at rise c+2+j.
    task automatic cap_shift(input logic [15:0] w, input string nm);
        int c;
        c = cyc;
        for (int j = 0; j < 16; j++) push(c + 2 + j, 1, {15'd0, w[j]}, $sformatf("%s_b%0d", nm, j));
        ijtag_ce = 1'b1;
        step();
        ijtag_ce = 1'b0;
        ijtag_se = 1'b1;
        repeat (16) step();
        ijtag_se = 1'b0;
    endtask

    initial begin
        int c;
        // Reset state
        step();
        step();
        push(cyc + 1, 0, 16'h0, "rst_out");
        push(cyc + 1, 1, 16'h0, "rst_so");
        step();
        ijtag_reset = 1'b1;
        push(cyc + 1, 0, 16'hF, "rst_release");
        step();
        ijtag_sel = 1'b1;
        cap_shift(16'h30F0, "rst_img");

        // Level override
        shift_word(16'h3005);
        c = cyc;
        push(c + 1, 0, 16'hA, "level");
        push(c + 2, 0, 16'hA, "level_hold");
        update();
        step();
        shift_word(16'h3000);
        c = cyc;
        push(c + 1, 0, 16'hF, "level_off");
        update();
        step();

        // Pulse pw=2 on ch0: 3 low periods
        shift_word(16'h21F1);
        c = cyc;
        for (int k = 1; k <= 3; k++) push(c + k, 0, 16'hE, $sformatf("pulse2_p%0d", k));
        push(c + 4, 0, 16'hF, "pulse2_end");
        push(c + 5, 0, 16'hF, "pulse2_after");
        update();
        repeat (5) step();
        cap_shift(16'h21F0, "cap_after_pulse");

        // Retrigger: pw=5, re-update at period 3 -> 9 low periods
        shift_word(16'h51E1);
        c = cyc;
        for (int k = 1; k <= 9; k++) push(c + k, 0, 16'hE, $sformatf("retrig_p%0d", k));
        push(c + 10, 0, 16'hF, "retrig_end");
        update();
        step();
        step();
        update();
        repeat (7) step();

        // Abort: shift register still holds the pulse word; one shift of 0
        // turns it into an all-ovr=0 image.
        c = cyc;
        push(c + 1, 0, 16'hE, "abort_p1");
        push(c + 2, 0, 16'hE, "abort_p2");
        push(c + 3, 0, 16'hF, "abort_high");
        push(c + 4, 0, 16'hF, "abort_stay");
        update();
        ijtag_se = 1'b1;
        ijtag_si = 1'b0;
        step();
        ijtag_se = 1'b0;
        update();
        step();

        // pw=0 -> 1 period
        shift_word(16'h01F1);
        c = cyc;
        push(c + 1, 0, 16'hE, "pw0_low");
        push(c + 2, 0, 16'hF, "pw0_end");
        update();
        step();
        step();

        // pw=15 -> 16 periods, no wrap
        shift_word(16'hF1F1);
        c = cyc;
        for (int k = 1; k <= 16; k++) push(c + k, 0, 16'hE, $sformatf("pw15_p%0d", k));
        push(c + 17, 0, 16'hF, "pw15_end");
        update();
        repeat (17) step();

        // Update with sel=0 is ignored; with sel=1 the held word applies
        shift_word(16'h000F);
        ijtag_sel = 1'b0;
        c = cyc;
        push(c + 1, 0, 16'hF, "nosel_upd");
        push(c + 2, 0, 16'hF, "nosel_hold");
        update();
        step();
        ijtag_sel = 1'b1;
        c = cyc;
        push(c + 1, 0, 16'h0, "sel_upd_level0");
        update();
        step();
        shift_word(16'h3000);
        c = cyc;
        push(c + 1, 0, 16'hF, "level0_off");
        update();
        step();

        // Reset mid-pulse: ch0 pulse pw=5, ch1 level high
        shift_word(16'h51E3);
        c = cyc;
        push(c + 1, 0, 16'hE, "mid_p1");
        push(c + 2, 0, 16'hE, "mid_p2");
        push(c + 3, 2, 16'h0, "mid_async");
        push(c + 3, 0, 16'h0, "mid_rst_out");
        push(c + 3, 1, 16'h0, "mid_rst_so");
        push(c + 4, 0, 16'h0, "mid_rst_hold");
        push(c + 5, 0, 16'hF, "mid_release");
        update();
        step();
        ijtag_reset = 1'b0;
        step();
        step();
        ijtag_reset = 1'b1;
        step();
        cap_shift(16'h30F0, "post_rst_img");

        for (int i = 0; i < 50 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain %0d expectations left unchecked", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
